// File: rtl/coloring_pkg.sv
// -----------------------------------------------------------------------------
// coloring_pkg
// Shared definitions for the colouring checker: FSM state encoding, the
// "uncoloured" colour value, default memory map addresses and small helpers.
// Optional feature macro: CHECK_LED_EN (adds the RD_LED state).
// -----------------------------------------------------------------------------
package coloring_pkg;

    // Default memory map of the four-colour system
    localparam int NUM_AREAS_DEF = 33;
    localparam int IDX_BASE_DEF  = 33;
    localparam int LED_BASE_DEF  = 215;

    // Colour slot value meaning "area not coloured yet"
    localparam logic [7:0] COLOR_NONE = 8'd0;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_RD_OWN  = 4'd1,
        ST_RD_BEG  = 4'd2,
        ST_RD_END  = 4'd3,
        ST_RD_NBR  = 4'd4,
        ST_RD_NCOL = 4'd5,
        ST_NEXT    = 4'd6,
`ifdef CHECK_LED_EN
        ST_RD_LED  = 4'd7,
`endif
        ST_DONE    = 4'd8
    } state_t;

    // Increment that sticks at the all-ones value
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    // Clamp a count to a single decimal digit
    function automatic logic [7:0] clamp_digit(input logic [7:0] v);
        return (v > 8'd9) ? 8'd9 : v;
    endfunction

endpackage

// File: rtl/coloring_checker_if.sv
// -----------------------------------------------------------------------------
// coloring_checker_if
// Data memory port shared with the CPU through the address/data mux.
//   mem_addr  : byte address from the initiator
//   mem_we    : write enable from the initiator
//   mem_wdata : write data from the initiator
//   mem_rdata : read data, combinational from mem_addr
// Modports: master = bus initiator (checker), slave = memory side.
// -----------------------------------------------------------------------------
interface coloring_checker_if;
    logic [7:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_we,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_we,
        input  mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/coloring_checker.sv
// -----------------------------------------------------------------------------
// coloring_checker
// Read-only bus initiator that walks the area colour slots and the adjacency
// table after the CPU has finished, and reports whether the map colouring is
// complete and conflict-free.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : one-cycle check request (ignored unless idle)
//   bus          : data memory port (master modport), reads only
//   busy         : check in progress
//   done         : one-cycle completion pulse
//   ok           : complete and no conflicts (valid from done to next start)
//   complete     : every area has a non-zero colour
//   err_cnt      : directed conflict count, saturating at 255
//   bad_a, bad_b : first conflicting area and its neighbour (FF = none)
//   led_seg      : 7-segment pattern of min(err_cnt,9), only with CHECK_LED_EN
// Every read takes one cycle: mem_addr is a register set on the transition
// into the state that consumes the data, and mem_rdata is latched on the edge
// that leaves that state.
// -----------------------------------------------------------------------------
module coloring_checker
    import coloring_pkg::*;
#(
    parameter int NUM_AREAS = NUM_AREAS_DEF,
    parameter int IDX_BASE  = IDX_BASE_DEF,
    parameter int LED_BASE  = LED_BASE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    coloring_checker_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  ok,
    output logic                  complete,
    output logic [7:0]            err_cnt,
    output logic [7:0]            bad_a,
    output logic [7:0]            bad_b
`ifdef CHECK_LED_EN
    ,
    output logic [7:0]            led_seg
`endif
);

    localparam logic [7:0] NUM_AREAS_B = 8'(NUM_AREAS);
    localparam logic [7:0] IDX_BASE_B  = 8'(IDX_BASE);
    localparam logic [7:0] LED_BASE_B  = 8'(LED_BASE);

    state_t     state_r;
    logic [7:0] mem_addr_r;
    logic [7:0] area_r;
    logic [7:0] own_r;
    logic [7:0] ptr_r;
    logic [7:0] end_r;
    logic [7:0] nbr_r;

    logic [7:0] area_inc_s;
    logic [7:0] ptr_inc_s;
    logic       conflict_s;
    logic       pass_s;

    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_we    = 1'b0;
    assign bus.mem_wdata = 8'd0;

    assign area_inc_s = area_r + 8'd1;
    assign ptr_inc_s  = ptr_r + 8'd1;
    // An uncoloured area never conflicts, even with uncoloured neighbours
    assign conflict_s = (own_r != COLOR_NONE) && (bus.mem_rdata == own_r);
    assign pass_s     = complete && (err_cnt == 8'd0);

    // Check sequencer: area walk, neighbour walk and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            mem_addr_r <= 8'd0;
            area_r     <= 8'd0;
            own_r      <= 8'd0;
            ptr_r      <= 8'd0;
            end_r      <= 8'd0;
            nbr_r      <= 8'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ok         <= 1'b0;
            complete   <= 1'b0;
            err_cnt    <= 8'd0;
            bad_a      <= 8'hFF;
            bad_b      <= 8'hFF;
`ifdef CHECK_LED_EN
            led_seg    <= 8'hFF;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        area_r     <= 8'd0;
                        err_cnt    <= 8'd0;
                        complete   <= 1'b1;
                        ok         <= 1'b0;
                        bad_a      <= 8'hFF;
                        bad_b      <= 8'hFF;
                        mem_addr_r <= 8'd0;
                        busy       <= 1'b1;
                        state_r    <= ST_RD_OWN;
                    end
                end
                ST_RD_OWN: begin
                    own_r <= bus.mem_rdata;
                    if (bus.mem_rdata == COLOR_NONE) begin
                        complete <= 1'b0;
                    end
                    mem_addr_r <= IDX_BASE_B + area_r;
                    state_r    <= ST_RD_BEG;
                end
                ST_RD_BEG: begin
                    ptr_r      <= bus.mem_rdata;
                    mem_addr_r <= IDX_BASE_B + area_inc_s;
                    state_r    <= ST_RD_END;
                end
                ST_RD_END: begin
                    end_r <= bus.mem_rdata;
                    if (bus.mem_rdata == ptr_r) begin
                        state_r <= ST_NEXT;
                    end else begin
                        mem_addr_r <= ptr_r;
                        state_r    <= ST_RD_NBR;
                    end
                end
                ST_RD_NBR: begin
                    nbr_r      <= bus.mem_rdata;
                    mem_addr_r <= bus.mem_rdata;
                    state_r    <= ST_RD_NCOL;
                end
                ST_RD_NCOL: begin
                    if (conflict_s) begin
                        err_cnt <= sat_inc8(err_cnt);
                        if (err_cnt == 8'd0) begin
                            bad_a <= area_r;
                            bad_b <= nbr_r;
                        end
                    end
                    ptr_r <= ptr_inc_s;
                    if (ptr_inc_s == end_r) begin
                        state_r <= ST_NEXT;
                    end else begin
                        mem_addr_r <= ptr_inc_s;
                        state_r    <= ST_RD_NBR;
                    end
                end
                ST_NEXT: begin
                    area_r <= area_inc_s;
                    if (area_inc_s == NUM_AREAS_B) begin
`ifdef CHECK_LED_EN
                        mem_addr_r <= LED_BASE_B + clamp_digit(err_cnt);
                        state_r    <= ST_RD_LED;
`else
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        ok      <= pass_s;
                        state_r <= ST_DONE;
`endif
                    end else begin
                        mem_addr_r <= area_inc_s;
                        state_r    <= ST_RD_OWN;
                    end
                end
`ifdef CHECK_LED_EN
                ST_RD_LED: begin
                    led_seg <= bus.mem_rdata;
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    ok      <= pass_s;
                    state_r <= ST_DONE;
                end
`endif
                ST_DONE: begin
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
